// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two valid/ready requesters.
// It holds a single registered result until the owning requester takes it, and keeps performance counters.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_A,
    input  logic [DATA_WIDTH-1:0] req0_B,
    input  logic [2:0]            req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_A,
    input  logic [DATA_WIDTH-1:0] req1_B,
    input  logic [2:0]            req1_op,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_overflow,
    output logic                  rsp_carryout,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [2:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_overflow,
    input  logic                  alu_carryout,
    output logic [CNT_WIDTH-1:0]  cnt_grant0,
    output logic [CNT_WIDTH-1:0]  cnt_grant1,
    output logic [CNT_WIDTH-1:0]  cnt_conflict
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t state;
    logic   owner;
    logic   ptr;
    logic   window;
    logic   winner;
    logic   grant;
    logic   conflict;

    // A new grant is possible when nothing is held, or when the owner drains its result this cycle.
    always_comb begin
        window = 1'b0;
        if (state == IDLE) begin
            window = 1'b1;
        end else begin
            window = owner ? rsp1_ready : rsp0_ready;
        end

        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ptr;
        end else if (req1_valid) begin
            winner = 1'b1;
        end

        grant    = window && (req0_valid || req1_valid);
        conflict = req0_valid && req1_valid;
    end

    assign req0_ready = grant && !winner;
    assign req1_ready = grant && winner;

    always_comb begin
        alu_A  = '0;
        alu_B  = '0;
        alu_op = 3'b000;
        if (grant) begin
            alu_A  = winner ? req1_A  : req0_A;
            alu_B  = winner ? req1_B  : req0_B;
            alu_op = winner ? req1_op : req0_op;
        end
    end

    // Only one requester can ever be accepted, so every both-valid cycle leaves one of them waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= 1'b0;
            ptr          <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_carryout <= 1'b0;
            cnt_grant0   <= '0;
            cnt_grant1   <= '0;
            cnt_conflict <= '0;
        end else begin
            if (grant) begin
                state        <= HOLD;
                owner        <= winner;
                ptr          <= ~winner;
                rsp0_valid   <= ~winner;
                rsp1_valid   <= winner;
                rsp_result   <= alu_result;
                rsp_zero     <= alu_zero;
                rsp_overflow <= alu_overflow;
                rsp_carryout <= alu_carryout;
                if (winner) begin
                    cnt_grant1 <= cnt_grant1 + CNT_WIDTH'(1);
                end else begin
                    cnt_grant0 <= cnt_grant0 + CNT_WIDTH'(1);
                end
            end else if (state == HOLD && window) begin
                state      <= IDLE;
                rsp0_valid <= 1'b0;
                rsp1_valid <= 1'b0;
            end
            if (conflict) begin
                cnt_conflict <= cnt_conflict + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: the bench plays the ALU and compares against a cycle-level reference model.
// A second instance with 4-bit counters, driven by the same stimulus, exposes counter wrap-around.
module tb_alu_share_arbiter;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_A, req0_B, req1_A, req1_B;
    logic [2:0]    req0_op, req1_op;
    logic          rsp0_ready, rsp1_ready;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_result, alu_A, alu_B, alu_result;
    logic          rsp_zero, rsp_overflow, rsp_carryout;
    logic [2:0]    alu_op;
    logic          alu_zero, alu_overflow, alu_carryout;
    logic [31:0]   cnt_grant0, cnt_grant1, cnt_conflict;

    logic          sm_req0_ready, sm_req1_ready, sm_rsp0_valid, sm_rsp1_valid;
    logic [DW-1:0] sm_rsp_result, sm_alu_A, sm_alu_B;
    logic          sm_rsp_zero, sm_rsp_overflow, sm_rsp_carryout;
    logic [2:0]    sm_alu_op;
    logic [3:0]    sm_cnt_grant0, sm_cnt_grant1, sm_cnt_conflict;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic        m_held, m_owner, m_ptr;
    logic [31:0] m_res;
    logic        m_z, m_o, m_c;
    logic [31:0] m_g0, m_g1, m_cf;

    alu_share_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_carryout(rsp_carryout),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carryout(alu_carryout),
        .cnt_grant0(cnt_grant0), .cnt_grant1(cnt_grant1), .cnt_conflict(cnt_conflict)
    );

    alu_share_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(sm_req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(sm_req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
        .rsp0_valid(sm_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(sm_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(sm_rsp_result), .rsp_zero(sm_rsp_zero), .rsp_overflow(sm_rsp_overflow),
        .rsp_carryout(sm_rsp_carryout),
        .alu_A(sm_alu_A), .alu_B(sm_alu_B), .alu_op(sm_alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carryout(alu_carryout),
        .cnt_grant0(sm_cnt_grant0), .cnt_grant1(sm_cnt_grant1), .cnt_conflict(sm_cnt_conflict)
    );

    // Returns {carryout, overflow, zero, result} for MIPS-style ALU ops; undefined ops give 0.
    function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        o;
        logic        c;
        r = '0;
        o = 1'b0;
        c = 1'b0;
        s = '0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b110: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0];
                c = s[32];
                o = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b111: r = {31'b0, ($signed(a) < $signed(b))};
            default: r = '0;
        endcase
        return {c, o, (r == 32'd0), r};
    endfunction

    always_comb begin
        {alu_carryout, alu_overflow, alu_zero, alu_result} = alu_fn(alu_A, alu_B, alu_op);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        m_held = 1'b0; m_owner = 1'b0; m_ptr = 1'b0;
        m_res = '0; m_z = 1'b0; m_o = 1'b0; m_c = 1'b0;
        m_g0 = '0; m_g1 = '0; m_cf = '0;
    endtask

    // One clock cycle: drive, check combinational outputs, advance model at the edge, check registered outputs.
    task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                        input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                        input logic r0, input logic r1);
        logic        e_window, e_win, e_grant;
        logic [31:0] e_a, e_b;
        logic [2:0]  e_op;
        req0_valid = v0; req0_A = a0; req0_B = b0; req0_op = op0;
        req1_valid = v1; req1_A = a1; req1_B = b1; req1_op = op1;
        rsp0_ready = r0; rsp1_ready = r1;
        #1;
        e_window = !m_held || (m_owner ? r1 : r0);
        e_win    = (v0 && v1) ? m_ptr : v1;
        e_grant  = e_window && (v0 || v1);
        e_a  = e_grant ? (e_win ? a1 : a0) : 32'd0;
        e_b  = e_grant ? (e_win ? b1 : b0) : 32'd0;
        e_op = e_grant ? (e_win ? op1 : op0) : 3'b000;
        checks++;
        if ({req0_ready, req1_ready} !== {e_grant && !e_win, e_grant && e_win}) begin
            errors++;
            $display("[TB] FAIL ready: got %b%b expected %b%b", req0_ready, req1_ready, e_grant && !e_win, e_grant && e_win);
        end
        checks++;
        if ({alu_A, alu_B, alu_op} !== {e_a, e_b, e_op}) begin
            errors++;
            $display("[TB] FAIL alu_operands: got %h %h %h expected %h %h %h", alu_A, alu_B, alu_op, e_a, e_b, e_op);
        end
        @(posedge clk);
        if (v0 && v1) m_cf++;
        if (e_grant) begin
            m_held = 1'b1;
            m_owner = e_win;
            m_ptr = !e_win;
            {m_c, m_o, m_z, m_res} = alu_fn(e_a, e_b, e_op);
            if (e_win) m_g1++; else m_g0++;
        end else if (m_held && e_window) begin
            m_held = 1'b0;
        end
        #1;
        checks++;
        if ({rsp0_valid, rsp1_valid} !== {m_held && !m_owner, m_held && m_owner}) begin
            errors++;
            $display("[TB] FAIL rsp_valid: got %b%b expected %b%b", rsp0_valid, rsp1_valid, m_held && !m_owner, m_held && m_owner);
        end
        if (m_held) begin
            checks++;
            if ({rsp_carryout, rsp_overflow, rsp_zero, rsp_result} !== {m_c, m_o, m_z, m_res}) begin
                errors++;
                $display("[TB] FAIL rsp_data: got c%b o%b z%b %h expected c%b o%b z%b %h",
                         rsp_carryout, rsp_overflow, rsp_zero, rsp_result, m_c, m_o, m_z, m_res);
            end
        end
        checks++;
        if ({cnt_grant0, cnt_grant1, cnt_conflict} !== {m_g0, m_g1, m_cf}) begin
            errors++;
            $display("[TB] FAIL counters: got %h %h %h expected %h %h %h", cnt_grant0, cnt_grant1, cnt_conflict, m_g0, m_g1, m_cf);
        end
        checks++;
        if ({sm_cnt_grant0, sm_cnt_grant1, sm_cnt_conflict} !== {m_g0[3:0], m_g1[3:0], m_cf[3:0]}) begin
            errors++;
            $display("[TB] FAIL small_counters: got %h %h %h expected %h %h %h",
                     sm_cnt_grant0, sm_cnt_grant1, sm_cnt_conflict, m_g0[3:0], m_g1[3:0], m_cf[3:0]);
        end
    endtask

    task automatic idle_cycle();
        step(1'b0, 32'd0, 32'd0, 3'b000, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_overflow, rsp_carryout} !== 36'd0) begin
            errors++;
            $display("[TB] FAIL reset_rsp: got %b %b %h expected all zero", rsp0_valid, rsp1_valid, rsp_result);
        end
        checks++;
        if ({cnt_grant0, cnt_grant1, cnt_conflict} !== 96'd0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got %h %h %h expected 0", cnt_grant0, cnt_grant1, cnt_conflict);
        end
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_single_add();
        do_reset();
        step(1'b1, 32'd5, 32'd7, 3'b010, 1'b0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0);
        checks++;
        if ({rsp0_valid, rsp_result, rsp_zero} !== {1'b1, 32'd12, 1'b0}) begin
            errors++;
            $display("[TB] FAIL single_add: got v%b %h z%b expected v1 0000000c z0", rsp0_valid, rsp_result, rsp_zero);
        end
        idle_cycle();
    endtask

    task automatic test_both_valid();
        do_reset();
        step(1'b1, 32'd3, 32'd3, 3'b110, 1'b1, 32'hF0, 32'h0F, 3'b001, 1'b0, 1'b0);
        checks++;
        if ({rsp0_valid, rsp_result, rsp_zero} !== {1'b1, 32'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL both_first: got v%b %h z%b expected v1 00000000 z1", rsp0_valid, rsp_result, rsp_zero);
        end
        step(1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 32'hF0, 32'h0F, 3'b001, 1'b1, 1'b0);
        checks++;
        if ({rsp1_valid, rsp_result, cnt_conflict} !== {1'b1, 32'hFF, 32'd1}) begin
            errors++;
            $display("[TB] FAIL both_second: got v%b %h cf%0d expected v1 000000ff cf1", rsp1_valid, rsp_result, cnt_conflict);
        end
        idle_cycle();
    endtask

    task automatic test_hold_stall();
        logic [31:0] cf_base;
        cf_base = m_cf;
        step(1'b1, 32'h7FFFFFFF, 32'd1, 3'b010, 1'b1, 32'd9, 32'd4, 3'b110, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 32'd9, 32'd4, 3'b110, 1'b0, 1'b1);
        end
        checks++;
        if ({rsp0_valid, rsp_result, rsp_overflow, cnt_conflict - cf_base} !== {1'b1, 32'h80000000, 1'b1, 32'd1}) begin
            errors++;
            $display("[TB] FAIL hold_stall: got v%b %h o%b cf+%0d expected v1 80000000 o1 cf+1",
                     rsp0_valid, rsp_result, rsp_overflow, cnt_conflict - cf_base);
        end
        step(1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 32'd9, 32'd4, 3'b110, 1'b1, 1'b1);
        idle_cycle();
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, $urandom, $urandom, 3'b010, 1'b1, $urandom, $urandom, 3'b001, 1'b1, 1'b1);
            checks++;
            if (rsp1_valid !== logic'(i % 2)) begin
                errors++;
                $display("[TB] FAIL alternate_%0d: got owner1=%b expected %b", i, rsp1_valid, logic'(i % 2));
            end
        end
        checks++;
        if ({cnt_grant0, cnt_grant1} !== {32'd4, 32'd4}) begin
            errors++;
            $display("[TB] FAIL alternate_counts: got %0d %0d expected 4 4", cnt_grant0, cnt_grant1);
        end
        idle_cycle();
    endtask

    task automatic test_random();
        logic [2:0] ops [6];
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011};
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), $urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom, ops[$urandom_range(0, 5)],
                 1'($urandom), $urandom, $urandom, ops[$urandom_range(0, 5)],
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end
        idle_cycle();
    endtask

    task automatic test_reset_in_hold();
        step(1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 32'd2, 32'd2, 3'b010, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_in_hold: got %b%b expected 00", rsp0_valid, rsp1_valid);
        end
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if ({cnt_grant0, cnt_grant1, cnt_conflict} !== 96'd0) begin
            errors++;
            $display("[TB] FAIL reset_in_hold_counters: got %h %h %h expected 0", cnt_grant0, cnt_grant1, cnt_conflict);
        end
        step(1'b1, 32'd1, 32'd1, 3'b010, 1'b1, 32'd1, 32'd1, 3'b001, 1'b1, 1'b1);
        checks++;
        if (rsp0_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_hold_ptr: got rsp0_valid=%b expected 1", rsp0_valid);
        end
        idle_cycle();
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 17 && m_g0[3:0] != 4'hF; i++) begin
            step(1'b1, 32'd1, 32'd2, 3'b010, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 1'b1);
        end
        checks++;
        if (sm_cnt_grant0 !== 4'hF) begin
            errors++;
            $display("[TB] FAIL wrap_preload: got %h expected f", sm_cnt_grant0);
        end
        step(1'b1, 32'd1, 32'd2, 3'b010, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 1'b1);
        checks++;
        if (sm_cnt_grant0 !== 4'h0) begin
            errors++;
            $display("[TB] FAIL wrap_rollover: got %h expected 0", sm_cnt_grant0);
        end
        idle_cycle();
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_A = '0; req0_B = '0; req0_op = '0;
        req1_valid = 1'b0; req1_A = '0; req1_B = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_single_add();
        test_both_valid();
        test_hold_stall();
        test_alternate();
        test_random();
        test_reset_in_hold();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
